voq_req_ctrl: RTL and testbench

Per-input virtual-output-queue (VOQ) request controller for the 4x4 switch core, sitting directly upstream of the iSLIP arbiter. It keeps a pending-frame count for every (input, output) pair from ingress enqueue events. It presents a registered request matrix to the arbiter through a valid/ready handshake, consumes the arbiter's one-hot grant vectors, and issues one dequeue command per granted input back to the VOQ buffers.

---
 rtl/voq_req_ctrl_pkg.sv | 29 ++
 rtl/voq_req_ctrl_if.sv | 28 ++
 rtl/voq_req_ctrl_cnt.sv | 25 ++
 rtl/voq_req_ctrl.sv | 112 +++++++++++
 tb/tb_voq_req_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/voq_req_ctrl_pkg.sv
// Shared types, state encodings and helpers for the VOQ request controller.
package voq_req_ctrl_pkg;

  localparam int unsigned PORT_NUM_DEF  = 4;
  localparam int unsigned CNT_WIDTH_DEF = 8;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    REQ   = 4'b0010,
    WAIT  = 4'b0100,
    ISSUE = 4'b1000
  } state_t;

  typedef logic [1:0] port_idx_t;
  typedef logic [PORT_NUM_DEF-1:0][PORT_NUM_DEF-1:0] port_mat_t;

  function automatic port_idx_t oh2bin(input logic [PORT_NUM_DEF-1:0] oh);
    port_idx_t idx;
    idx = '0;
    for (int unsigned k = 0; k < PORT_NUM_DEF; k++)
      if (oh[k]) idx = port_idx_t'(k);
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [PORT_NUM_DEF-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/voq_req_ctrl_if.sv
// Enqueue, arbiter handshake and dequeue signals of the VOQ request controller.
interface voq_req_ctrl_if;
  import voq_req_ctrl_pkg::*;

  logic [3:0]      enq_valid;
  logic [3:0][1:0] enq_dst;
  logic [3:0]      enq_ready;
  logic [3:0]      tx_rdy_vect;
  logic            arb_valid_in;
  logic            arb_ready_in;
  port_mat_t       rx_req_vect;
  logic            arb_valid_out;
  logic            arb_ready_out;
  port_mat_t       arb_vect;
  logic [3:0]      deq_valid;
  logic [3:0][1:0] deq_dst;
  logic            grant_err;

  modport master (
    output enq_valid, enq_dst, tx_rdy_vect, arb_ready_in, arb_valid_out, arb_vect,
    input  enq_ready, arb_valid_in, rx_req_vect, arb_ready_out, deq_valid, deq_dst, grant_err
  );

  modport slave (
    input  enq_valid, enq_dst, tx_rdy_vect, arb_ready_in, arb_valid_out, arb_vect,
    output enq_ready, arb_valid_in, rx_req_vect, arb_ready_out, deq_valid, deq_dst, grant_err
  );
endinterface

// File: rtl/voq_req_ctrl_cnt.sv
// Saturating up/down pending-frame counter for one (input, output) pair.
module voq_cnt #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic sat,
  output logic zero
);
  logic [CNT_WIDTH-1:0] cnt;

  assign sat  = (cnt == '1);
  assign zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc && !dec && !sat)
      cnt <= cnt + 1'b1;
    else if (dec && !inc && !zero)
      cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/voq_req_ctrl.sv
// VOQ request controller: per-pair frame counters, request snapshot, arbiter
// handshake and one dequeue command per validly granted input.
module voq_req_ctrl
  import voq_req_ctrl_pkg::*;
#(
  parameter int unsigned PORT_NUM  = PORT_NUM_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  voq_req_ctrl_if.slave bus
);
  state_t          state;
  port_mat_t       req_reg, req_snap, inc, dec, sat, zero;
  logic [3:0]      enq_rdy, deq_ok, gnt_bad;
  logic [3:0][1:0] deq_idx;
  logic [3:0]      deq_valid_r;
  logic [3:0][1:0] deq_dst_r;
  logic            arb_valid_r, arb_ready_r, err_r;

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
      voq_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc[i][o]),
        .dec  (dec[i][o]),
        .sat  (sat[i][o]),
        .zero (zero[i][o])
      );
    end
  end

  always_comb begin
    enq_rdy  = '0;
    inc      = '0;
    dec      = '0;
    req_snap = '0;
    deq_idx  = '0;
    deq_ok   = '0;
    gnt_bad  = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      for (int unsigned o = 0; o < PORT_NUM; o++) begin
        dec[i][o]      = deq_valid_r[i] && (deq_dst_r[i] == port_idx_t'(o));
        req_snap[i][o] = !zero[i][o] && bus.tx_rdy_vect[o];
      end
      // A same-cycle decrement frees a slot in a saturated counter.
      enq_rdy[i] = !sat[i][bus.enq_dst[i]] || dec[i][bus.enq_dst[i]];
      for (int unsigned o = 0; o < PORT_NUM; o++)
        inc[i][o] = bus.enq_valid[i] && enq_rdy[i] && (bus.enq_dst[i] == port_idx_t'(o));
      deq_idx[i] = oh2bin(bus.arb_vect[i]);
      deq_ok[i]  = is_onehot(bus.arb_vect[i]) && ((bus.arb_vect[i] & ~req_reg[i]) == '0)
                   && !zero[i][deq_idx[i]];
      gnt_bad[i] = (bus.arb_vect[i] != '0) && !deq_ok[i];
    end
  end

  // The grant is checked and decoded as it is captured, so the registered
  // deq_valid/deq_dst pair is the validated grant register used during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_reg     <= '0;
      arb_valid_r <= 1'b0;
      arb_ready_r <= 1'b0;
      deq_valid_r <= '0;
      deq_dst_r   <= '0;
      err_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_reg <= req_snap;
          if (req_snap != '0) begin
            arb_valid_r <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus.arb_ready_in) begin
            arb_valid_r <= 1'b0;
            arb_ready_r <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.arb_valid_out) begin
            arb_ready_r <= 1'b0;
            deq_valid_r <= deq_ok;
            for (int unsigned i = 0; i < PORT_NUM; i++)
              deq_dst_r[i] <= deq_ok[i] ? deq_idx[i] : port_idx_t'(0);
            err_r <= err_r | (gnt_bad != '0);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          req_reg     <= '0;
          deq_valid_r <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.enq_ready     = enq_rdy;
  assign bus.arb_valid_in  = arb_valid_r;
  assign bus.arb_ready_out = arb_ready_r;
  assign bus.rx_req_vect   = req_reg;
  assign bus.deq_valid     = deq_valid_r;
  assign bus.deq_dst       = deq_dst_r;
  assign bus.grant_err     = err_r;
endmodule

// File: tb/tb_voq_req_ctrl.sv
// Table-driven and scoreboard-checked bench for voq_req_ctrl.
module tb_voq_req_ctrl;
  import voq_req_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voq_req_ctrl_if bus ();

  voq_req_ctrl #(.PORT_NUM(4), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0]      dv;
    logic [3:0][1:0] dd;
    logic            err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string           name;
    logic [3:0]      enq_in;
    logic [3:0][1:0] dst;
    logic [3:0]      tx_rdy;
    port_mat_t       exp_req;
    port_mat_t       gnt;
    logic [3:0]      exp_dv;
    logic [3:0][1:0] exp_dd;
    logic            exp_err;
    logic            exp_again;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dmask(input logic [3:0] v);
    logic [7:0] m;
    for (int i = 0; i < 4; i++) m[2*i +: 2] = {2{v[i]}};
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.enq_valid     = '0;
    bus.enq_dst       = '0;
    bus.arb_ready_in  = 1'b0;
    bus.arb_valid_out = 1'b0;
    bus.arb_vect      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name, output int n);
    n = 0;
    while (!bus.arb_valid_in && n < 20) begin
      tick();
      n++;
    end
    chk({name, " req_seen"}, bus.arb_valid_in, 1);
  endtask

  // Arbiter side: accept the request, hold off 3 cycles, present the grant once.
  task automatic grant(input string name, input port_mat_t g);
    bus.arb_ready_in = 1'b1;
    tick();
    bus.arb_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s arb_ready_out w%0d", name, k), bus.arb_ready_out, 1);
      if (k < 2) tick();
    end
    bus.arb_valid_out = 1'b1;
    bus.arb_vect      = g;
    tick();
    bus.arb_valid_out = 1'b0;
    bus.arb_vect      = '0;
  endtask

  task automatic check_issue(input string name, input logic [3:0] ev,
                             input logic [3:0][1:0] ed, output logic [3:0] rdy);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", name);
      e = '{4'h0, 8'h00, 1'b0};
    end else begin
      e = sb.pop_front();
    end
    chk({name, " deq_valid"}, bus.deq_valid, e.dv);
    chk({name, " deq_dst"}, bus.deq_dst & dmask(e.dv), e.dd & dmask(e.dv));
    bus.enq_valid = ev;
    bus.enq_dst   = ed;
    #1;
    rdy = bus.enq_ready;
    tick();
    bus.enq_valid = '0;
    chk({name, " grant_err"}, bus.grant_err, e.err);
  endtask

  task automatic watch(input int n, output logic saw_req, output logic saw_deq);
    saw_req = 1'b0;
    saw_deq = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (bus.arb_valid_in) saw_req = 1'b1;
      if (bus.deq_valid != '0) saw_deq = 1'b1;
      tick();
    end
  endtask

  initial begin
    int         n;
    logic       sr, sd;
    logic [3:0] rdy;
    int         cnt_m[4];
    int         ptr, sel, notrdy;
    port_mat_t  g, er;

    vecs[0] = '{"single",   4'b0010, 8'h08, 4'hf,    16'h0040, 16'h0040, 4'b0010, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{"parallel", 4'b1111, 8'hE4, 4'hf,    16'h8421, 16'h8421, 4'b1111, 8'hE4, 1'b0, 1'b0};
    vecs[2] = '{"partial",  4'b0011, 8'h0F, 4'hf,    16'h0088, 16'h0008, 4'b0001, 8'h03, 1'b0, 1'b1};
    vecs[3] = '{"multihot", 4'b1000, 8'h00, 4'hf,    16'h1000, 16'h3000, 4'b0000, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{"unreq",    4'b0100, 8'h10, 4'hf,    16'h0200, 16'h0400, 4'b0000, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{"txmask",   4'b0011, 8'h0B, 4'b0111, 16'h0040, 16'h0040, 4'b0010, 8'h08, 1'b0, 1'b0};

    bus.tx_rdy_vect = '1;
    do_reset();
    rst = 1'b1;
    tick();
    chk("rst arb_valid_in", bus.arb_valid_in, 0);
    chk("rst arb_ready_out", bus.arb_ready_out, 0);
    chk("rst deq_valid", bus.deq_valid, 0);
    chk("rst deq_dst", bus.deq_dst, 0);
    chk("rst grant_err", bus.grant_err, 0);
    chk("rst rx_req_vect", bus.rx_req_vect, 0);
    chk("rst enq_ready", bus.enq_ready, 4'hf);
    rst = 1'b0;

    foreach (vecs[v]) begin
      do_reset();
      bus.tx_rdy_vect = vecs[v].tx_rdy;
      bus.enq_valid   = vecs[v].enq_in;
      bus.enq_dst     = vecs[v].dst;
      tick();
      bus.enq_valid = '0;
      wait_req(vecs[v].name, n);
      chk({vecs[v].name, " req_latency"}, n, 1);
      chk({vecs[v].name, " rx_req_vect"}, bus.rx_req_vect, vecs[v].exp_req);
      sb.push_back('{vecs[v].exp_dv, vecs[v].exp_dd, vecs[v].exp_err});
      grant(vecs[v].name, vecs[v].gnt);
      check_issue(vecs[v].name, 4'h0, 8'h00, rdy);
      watch(8, sr, sd);
      chk({vecs[v].name, " next_request"}, sr, vecs[v].exp_again);
    end

    // Output masking: two frames held back until tx_rdy_vect[3] rises.
    do_reset();
    bus.tx_rdy_vect = 4'b0111;
    bus.enq_valid   = 4'b0001;
    bus.enq_dst     = 8'h03;
    tick();
    tick();
    bus.enq_valid = '0;
    watch(10, sr, sd);
    chk("mask held_off", sr, 0);
    bus.tx_rdy_vect = 4'hf;
    wait_req("mask", n);
    chk("mask rx_req_vect", bus.rx_req_vect, 16'h0008);
    bus.tx_rdy_vect = 4'b0111;
    sb.push_back('{4'b0001, 8'h03, 1'b0});
    grant("mask", 16'h0008);
    check_issue("mask", 4'h0, 8'h00, rdy);
    watch(10, sr, sd);
    chk("mask single_request", sr, 0);

    // Full contention: every input holds 3 frames for output 0.
    do_reset();
    bus.tx_rdy_vect = 4'hf;
    bus.enq_valid   = 4'hf;
    bus.enq_dst     = 8'h00;
    for (int k = 0; k < 3; k++) tick();
    bus.enq_valid = '0;
    foreach (cnt_m[i]) cnt_m[i] = 3;
    ptr = 0;
    for (int k = 0; k < 12; k++) begin
      wait_req($sformatf("cont%0d", k), n);
      er = '0;
      for (int i = 0; i < 4; i++) if (cnt_m[i] != 0) er[i] = 4'b0001;
      chk($sformatf("cont%0d rx_req_vect", k), bus.rx_req_vect, er);
      sel = -1;
      for (int j = 0; j < 4; j++)
        if (sel < 0 && cnt_m[(ptr + j) % 4] != 0) sel = (ptr + j) % 4;
      if (sel < 0) sel = 0;
      g = '0;
      g[sel] = 4'b0001;
      ptr = (sel + 1) % 4;
      cnt_m[sel]--;
      sb.push_back('{4'(1 << sel), 8'h00, 1'b0});
      grant($sformatf("cont%0d", k), g);
      check_issue($sformatf("cont%0d", k), 4'h0, 8'h00, rdy);
    end
    watch(10, sr, sd);
    chk("cont drained", sr, 0);

    // Saturation of cnt[2][1], then ISSUE decrement alongside an enqueue.
    do_reset();
    bus.tx_rdy_vect = 4'b1101;
    bus.enq_dst     = 8'h10;
    bus.enq_valid   = 4'b0100;
    notrdy = 0;
    for (int k = 0; k < 255; k++) begin
      if (!bus.enq_ready[2]) notrdy++;
      tick();
    end
    chk("sat fill_ready", notrdy, 0);
    chk("sat full enq_ready", bus.enq_ready[2], 0);
    tick();
    bus.enq_valid = '0;
    #1;
    chk("sat dropped enq_ready", bus.enq_ready[2], 0);
    bus.tx_rdy_vect = 4'hf;
    wait_req("sat", n);
    chk("sat rx_req_vect", bus.rx_req_vect, 16'h0200);
    sb.push_back('{4'b0100, 8'h10, 1'b0});
    grant("sat", 16'h0200);
    bus.tx_rdy_vect = 4'b1101;
    check_issue("sat", 4'b0100, 8'h10, rdy);
    chk("sat issue enq_ready", rdy[2], 1);
    #1;
    chk("sat still_full", bus.enq_ready[2], 0);

    // Bad grant is sticky and leaves the counter for a later valid grant.
    do_reset();
    bus.tx_rdy_vect = 4'hf;
    bus.enq_valid   = 4'b1000;
    bus.enq_dst     = 8'h00;
    tick();
    bus.enq_valid = '0;
    wait_req("bad", n);
    sb.push_back('{4'b0000, 8'h00, 1'b1});
    grant("bad", 16'h3000);
    check_issue("bad", 4'h0, 8'h00, rdy);
    wait_req("bad retry", n);
    chk("bad retry rx_req_vect", bus.rx_req_vect, 16'h1000);
    sb.push_back('{4'b1000, 8'h00, 1'b1});
    grant("bad retry", 16'h1000);
    check_issue("bad retry", 4'h0, 8'h00, rdy);
    watch(8, sr, sd);
    chk("bad drained", sr, 0);

    // Reset while waiting for the arbiter result.
    do_reset();
    bus.enq_valid = 4'b0010;
    bus.enq_dst   = 8'h08;
    tick();
    bus.enq_valid = '0;
    wait_req("midrst", n);
    bus.arb_ready_in = 1'b1;
    tick();
    bus.arb_ready_in = 1'b0;
    chk("midrst in_wait", bus.arb_ready_out, 1);
    rst               = 1'b1;
    bus.arb_valid_out = 1'b1;
    bus.arb_vect      = 16'h0040;
    tick();
    rst               = 1'b0;
    bus.arb_valid_out = 1'b0;
    bus.arb_vect      = '0;
    chk("midrst arb_ready_out", bus.arb_ready_out, 0);
    chk("midrst arb_valid_in", bus.arb_valid_in, 0);
    chk("midrst deq_valid", bus.deq_valid, 0);
    chk("midrst rx_req_vect", bus.rx_req_vect, 0);
    chk("midrst grant_err", bus.grant_err, 0);
    watch(10, sr, sd);
    chk("midrst no_deq", sd, 0);
    chk("midrst no_req", sr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
